// File: rtl/mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_stage : pipeline memory stage; req/ack loads/stores, write-back.    |
// | Rev 1.0   : initial release                                             |
// +------------------------------------------------------------------------+
module mem_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [4:0]  rd_in,
   input  logic [31:0] res_in,
   input  logic [31:0] pc_in,
   input  logic [10:0] op_data_in,
   input  logic [31:0] store_data_in,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        wb_valid,
   output logic        wb_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        err,
   output logic [31:0] err_pc
);

   localparam int c_CNT_W = $clog2(TIMEOUT);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   state_t              r_state;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [4:0]          r_rd;
   logic [31:0]         r_res;
   logic [31:0]         r_pc;
   logic                r_rf_we;
   logic [1:0]          r_size;
   logic                r_uns;
   logic [1:0]          r_sel;

   logic                w_is_mem;
   logic [1:0]          w_size;
   logic                w_misal;
   logic [3:0]          w_be;
   logic [31:0]         w_wdata;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic [31:0]         w_load;
   logic                w_unused;

   assign w_unused = ^op_data_in[10:8];
   assign stall    = (r_state == S_ACCESS);
   assign w_is_mem = op_data_in[1] | op_data_in[2];
   assign w_size   = op_data_in[4:3];
   assign w_misal  = ((w_size == 2'b01) && res_in[0]) ||
                     (w_size[1] && (res_in[1:0] != 2'b00));

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = store_data_in;
      case (w_size)
         2'b00: begin
            w_be    = 4'b0001 << res_in[1:0];
            w_wdata = {4{store_data_in[7:0]}};
         end
         2'b01: begin
            w_be    = res_in[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{store_data_in[15:0]}};
         end
         default: ;
      endcase
   end

   // Load lane selection uses the address latched at request time.
   assign w_byte = mem_rdata[{r_res[1:0], 3'b000} +: 8];
   assign w_half = mem_rdata[{r_res[1], 4'b0000} +: 16];

   always_comb begin
      w_load = mem_rdata;
      case (r_size)
         2'b00:   w_load = {{24{w_byte[7] & ~r_uns}}, w_byte};
         2'b01:   w_load = {{16{w_half[15] & ~r_uns}}, w_half};
         default: ;
      endcase
   end

   function automatic logic [31:0] f_wb_sel(input logic [1:0] sel, input logic [31:0] res,
                                             input logic [31:0] ld, input logic [31:0] pc);
      case (sel)
         2'b01:   return ld;
         2'b10:   return pc + 32'd4;
         default: return res;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_rd      <= 5'd0;
         r_res     <= 32'd0;
         r_pc      <= 32'd0;
         r_rf_we   <= 1'b0;
         r_size    <= 2'b00;
         r_uns     <= 1'b0;
         r_sel     <= 2'b00;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_be    <= 4'd0;
         mem_wdata <= 32'd0;
         wb_valid  <= 1'b0;
         wb_we     <= 1'b0;
         wb_rd     <= 5'd0;
         wb_data   <= 32'd0;
         err       <= 1'b0;
         err_pc    <= 32'd0;
      end else begin
         wb_valid <= 1'b0;
         err      <= 1'b0;
         if (r_state == S_IDLE) begin
            if (valid_in) begin
               if (!w_is_mem) begin
                  wb_valid <= 1'b1;
                  wb_we    <= op_data_in[0] && (rd_in != 5'd0);
                  wb_rd    <= rd_in;
                  wb_data  <= f_wb_sel(op_data_in[7:6], res_in, 32'd0, pc_in);
               end else if (w_misal) begin
                  err      <= 1'b1;
                  err_pc   <= pc_in;
                  wb_valid <= 1'b1;
                  wb_we    <= 1'b0;
                  wb_rd    <= rd_in;
               end else begin
                  r_rd      <= rd_in;
                  r_res     <= res_in;
                  r_pc      <= pc_in;
                  r_rf_we   <= op_data_in[0];
                  r_size    <= w_size;
                  r_uns     <= op_data_in[5];
                  r_sel     <= op_data_in[7:6];
                  r_cnt     <= '0;
                  r_state   <= S_ACCESS;
                  mem_req   <= 1'b1;
                  mem_we    <= ~op_data_in[1];
                  mem_addr  <= {res_in[31:2], 2'b00};
                  mem_be    <= w_be;
                  mem_wdata <= w_wdata;
               end
            end
         end else begin
            // An ack on the final counted cycle takes precedence over the timeout.
            if (mem_ack) begin
               mem_req  <= 1'b0;
               r_state  <= S_IDLE;
               wb_valid <= 1'b1;
               wb_we    <= r_rf_we && (r_rd != 5'd0);
               wb_rd    <= r_rd;
               wb_data  <= f_wb_sel(r_sel, r_res, w_load, r_pc);
            end else if (r_cnt == c_CNT_W'(TIMEOUT - 1)) begin
               mem_req  <= 1'b0;
               r_state  <= S_IDLE;
               err      <= 1'b1;
               err_pc   <= r_pc;
               wb_valid <= 1'b1;
               wb_we    <= 1'b0;
               wb_rd    <= r_rd;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mem_stage : randomized bench for mem_stage with a behavioural model. |
// | Rev 1.0      : initial release                                          |
// +------------------------------------------------------------------------+
module tb_mem_stage;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [4:0]  rd_in;
   logic [31:0] res_in, pc_in, store_data_in;
   logic [10:0] op_data_in;
   logic        stall, mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        wb_valid, wb_we, err;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, err_pc;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] exp_err_pc = 32'd0;

   mem_stage #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .rd_in(rd_in), .res_in(res_in),
      .pc_in(pc_in), .op_data_in(op_data_in), .store_data_in(store_data_in),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .err(err), .err_pc(err_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_inputs;
      valid_in      = 1'($urandom);
      rd_in         = 5'($urandom);
      res_in        = $urandom;
      pc_in         = $urandom;
      op_data_in    = 11'($urandom);
      store_data_in = $urandom;
      mem_ack       = 1'($urandom);
      mem_rdata     = $urandom;
   endtask

   // Load value from lane arithmetic: shift the addressed lane down, mask, sign-extend.
   function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [1:0] a,
                                               input logic [1:0] size, input logic uns);
      logic [31:0] sh;
      sh = rdata >> (8 * a);
      if (size == 2'b00) return uns ? (sh & 32'hFF) : (((sh & 32'hFF) ^ 32'h80) - 32'h80);
      if (size == 2'b01) return uns ? (sh & 32'hFFFF) : (((sh & 32'hFFFF) ^ 32'h8000) - 32'h8000);
      return rdata;
   endfunction

   // delay = number of waiting cycles before ack; >= TIMEOUT means never.
   task automatic do_instr(input logic [4:0] rd, input logic [31:0] res, input logic [31:0] pc,
                           input logic [10:0] op, input logic [31:0] sd, input int delay,
                           input logic [31:0] rdata);
      logic        is_mem, is_load, mis, we_exp;
      int          nbytes;
      logic [31:0] wdata_exp, be_exp, data_exp;
      logic [1:0]  a;
      is_load = op[1];
      is_mem  = op[1] | op[2];
      nbytes  = (op[4:3] == 2'b00) ? 1 : (op[4:3] == 2'b01) ? 2 : 4;
      mis     = is_mem && ((res % nbytes) != 0);
      we_exp  = op[0] && (rd != 5'd0);
      a       = res[1:0];
      valid_in = 1'b1; rd_in = rd; res_in = res; pc_in = pc; op_data_in = op;
      store_data_in = sd; mem_ack = 1'($urandom); mem_rdata = $urandom;
      step;
      valid_in = 1'b0; mem_ack = 1'b0;
      if (!is_mem || mis) begin
         data_exp = (op[7:6] == 2'b10) ? pc + 32'd4 : res;
         check("flags_short", {stall, mem_req, wb_valid, err}, {3'b001, mis});
         check("wb_we_short", wb_we, mis ? 1'b0 : we_exp);
         check("wb_rd_short", wb_rd, rd);
         if (!mis) check("wb_data_short", wb_data, data_exp);
         if (mis) exp_err_pc = pc;
         check("err_pc_short", err_pc, exp_err_pc);
         return;
      end
      be_exp    = (nbytes == 1) ? (32'd1 << a) : (nbytes == 2) ? (32'd3 << a) : 32'hF;
      wdata_exp = (nbytes == 1) ? (sd & 32'hFF) * 32'h01010101 :
                  (nbytes == 2) ? (sd & 32'hFFFF) * 32'h00010001 : sd;
      check("req_start", {stall, mem_req, wb_valid, err}, 4'b1100);
      check("mem_we", mem_we, !is_load);
      check("mem_addr", mem_addr, res - a);
      check("mem_be", mem_be, be_exp);
      if (!is_load) check("mem_wdata", mem_wdata, wdata_exp);
      for (int k = 0; k < TIMEOUT; k++) begin
         randomize_inputs();
         mem_ack   = (k == delay);
         mem_rdata = (k == delay) ? rdata : $urandom;
         step;
         if (k == delay) begin
            case (op[7:6])
               2'b01:   data_exp = model_load(rdata, a, op[4:3], op[5]);
               2'b10:   data_exp = pc + 32'd4;
               default: data_exp = res;
            endcase
            check("flags_ack", {stall, mem_req, wb_valid, err}, 4'b0010);
            check("wb_we_ack", wb_we, we_exp);
            check("wb_rd_ack", wb_rd, rd);
            check("wb_data_ack", wb_data, data_exp);
            break;
         end else if (k == TIMEOUT - 1) begin
            exp_err_pc = pc;
            check("flags_tmo", {stall, mem_req, wb_valid, err}, 4'b0011);
            check("wb_we_tmo", wb_we, 1'b0);
            check("err_pc_tmo", err_pc, exp_err_pc);
         end else begin
            check("flags_wait", {stall, mem_req, wb_valid, err}, 4'b1100);
            check("addr_wait", mem_addr, res - a);
         end
      end
      valid_in = 1'b0; mem_ack = 1'b0;
   endtask

   initial begin
      logic [10:0] op;
      logic [31:0] res;
      rst = 1'b0;
      randomize_inputs();
      step;
      randomize_inputs();
      step;
      check("rst_outs", {stall, mem_req, mem_we, mem_be, wb_valid, wb_we, wb_rd, err}, 32'd0);
      check("rst_addr_wdata", mem_addr | mem_wdata, 32'd0);
      check("rst_wbdata_errpc", wb_data | err_pc, 32'd0);
      rst = 1'b1; valid_in = 1'b0; mem_ack = 1'b0;
      step;
      check("idle_outs", {stall, mem_req, wb_valid, err}, 32'd0);

      // Directed scenarios.
      do_instr(5'd5, 32'h1234, 32'h400, 11'h001, 32'h0, 0, 32'h0);
      do_instr(5'd0, 32'h1234, 32'h404, 11'h001, 32'h0, 0, 32'h0);
      do_instr(5'd7, 32'h103, 32'h408, 11'h043, 32'h0, 2, 32'h80123456);
      do_instr(5'd7, 32'h103, 32'h40C, 11'h063, 32'h0, 2, 32'h80123456);
      do_instr(5'd3, 32'h22, 32'h410, 11'h00C, 32'hABCD1234, 1, 32'h0);
      do_instr(5'd9, 32'h6, 32'h414, 11'h053, 32'h0, 0, 32'h0);
      do_instr(5'd9, 32'h40, 32'h418, 11'h053, 32'h0, 1000, 32'h0);
      do_instr(5'd4, 32'hFFFFFFFC, 32'hFFFFFFFC, 11'h081, 32'h0, 0, 32'h0);
      do_instr(5'd6, 32'h80, 32'h41C, 11'h053, 32'h0, TIMEOUT - 1, 32'hCAFEF00D);

      // Randomized instruction stream.
      for (int i = 0; i < 300; i++) begin
         op  = 11'($urandom);
         res = $urandom;
         if ($urandom_range(0, 3) != 0) res[1:0] = 2'b00;
         if (op[7:6] == 2'b01 && !op[1]) op[7:6] = 2'b00;
         do_instr(5'($urandom), res, $urandom, op, $urandom,
                  int'($urandom_range(0, TIMEOUT + 2)), $urandom);
      end

      // Reset while an access is outstanding.
      valid_in = 1'b1; rd_in = 5'd1; res_in = 32'h100; pc_in = 32'h500;
      op_data_in = 11'h053; mem_ack = 1'b0;
      step;
      valid_in = 1'b0;
      step;
      check("pre_rst_req", {stall, mem_req}, 2'b11);
      rst = 1'b0; mem_ack = 1'b1;
      step;
      check("rst_abort", {stall, mem_req, wb_valid, err}, 4'b0000);
      check("rst_abort_errpc", err_pc, 32'd0);
      rst = 1'b1; mem_ack = 1'b0;
      step;
      check("post_rst_idle", {stall, mem_req, wb_valid, err}, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the CPU pipeline. Consumes the registered outputs of the stage3 pipeline register (rd, result, PC, op_data) and performs loads and stores over a req/ack data-memory port. It stalls the upstream register while an access is outstanding and produces registered write-back signals for the register file. Misaligned accesses and memory timeouts are flagged as errors.

## Interface
- TIMEOUT, 16: maximum cycles in ACCESS without mem_ack before abort (≥2).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- valid_in  in  1  an instruction is presented on the *_in ports.
- rd_in  in  5  destination register.
- res_in  in  32  ALU result; the effective address for memory ops.
- pc_in  in  32  instruction PC.
- op_data_in  in  11  control: [0] reg_write, [1] mem_read, [2] mem_write, [4:3] size (00 byte, 01 half, 10 word, 11 word), [5] unsigned load, [7:6] wb_sel (00 res, 01 load data, 10 PC+4, 11 res), [10:8] reserved, ignored.
- store_data_in  in  32  store value, valid with valid_in.
- stall  out  1  high while state is ACCESS; drives upstream en low.
- mem_req  out  1  access request, held until ack or abort.
- mem_we  out  1  1 = store.
- mem_addr  out  32  word-aligned address ({res[31:2],2'b00}).
- mem_be  out  4  byte enables.
- mem_wdata  out  32  store data, lane-replicated.
- mem_ack  in  1  access complete; mem_rdata valid on loads.
- mem_rdata  in  32  load data.
- wb_valid  out  1  one-cycle pulse per retired instruction.
- wb_we  out  1  register-file write enable.
- wb_rd  out  5  write-back register.
- wb_data  out  32  write-back value.
- err  out  1  one-cycle pulse: misaligned or timeout.
- err_pc  out  32  PC of the last faulting instruction; held.

## Operation
- FSM states: IDLE, ACCESS.
- IDLE with valid_in and no mem op: no memory activity. Next edge: wb_valid=1, wb_we=reg_write&&(rd_in!=0), wb_rd=rd_in, wb_data per wb_sel (PC+4 = pc_in+32'd4, mod 2^32).
- IDLE with valid_in and mem_read or mem_write (mem_read has priority if both are set):
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Next edge: err=1, err_pc=pc_in, wb_valid=1, wb_we=0. No request is issued. State stays IDLE.
  - Aligned: next edge latches rd, pc, op, addr and store data into internal registers. Drives mem_req=1, mem_we, mem_addr, mem_be, mem_wdata. State goes to ACCESS. The timeout counter clears to 0.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0].
  - Half: addr[1] ? 4'b1100 : 4'b0011.
  - Word: 4'b1111.
  - Loads drive the same enables.
- mem_wdata:
  - Byte: {4{d[7:0]}}.
  - Half: {2{d[15:0]}}.
  - Word: d.
- ACCESS, mem_ack=1: next edge mem_req=0, state goes to IDLE, and write-back fires.
  - Load data is extracted by lane (byte: lane addr[1:0]; half: addr[1]).
  - Extension is sign or zero (zero when op[5]=1).
  - wb_sel=01 selects the extracted data.
  - Stores write back per wb_sel as usual.
- ACCESS, no ack: the counter increments. If the counter reaches TIMEOUT-1 without ack, next edge:
  - mem_req=0, state goes to IDLE.
  - err=1, err_pc=latched pc.
  - wb_valid=1, wb_we=0.
- valid_in is ignored in ACCESS. Upstream holds its inputs because stall=1.
- mem_ack in IDLE is ignored.

## Timing
- Reset (rst=0 at a rising edge): state=IDLE, counter=0. All outputs 0: stall, mem_*, wb_*, err, err_pc.
- Reset during ACCESS aborts: mem_req drops at that edge and no write-back occurs.
- Non-memory op or misaligned op: latency 1. valid_in at cycle N gives wb_valid at N+1. stall is never asserted.
- Memory op presented at cycle N:
  - mem_req and stall are high from N+1.
  - If ack is sampled at cycle M: wb_valid, mem_req=0 and stall=0 at M+1.
  - Minimum latency is 2 (ack at N+1).
- Back-to-back: the next instruction can be accepted in the cycle at which write-back occurs (M+1).
- stall is a decode of the state register only. It has no combinational path from valid_in or mem_ack.
- wb_valid and err are single-cycle pulses. All wb_* outputs are registered.
- Ack arriving in the same cycle the counter reaches TIMEOUT-1: ack wins and no err is raised.

## Test plan
- Reset with random inputs, rst=0 for 2 cycles → all outputs 0. Release with valid_in=0 → outputs remain 0.
- ALU op with rd=5, res=0x1234, wb_sel=00, reg_write=1 → next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x1234, stall=0. The same op with rd=0 gives wb_we=0.
- Signed byte load at addr 0x103, mem_rdata=0x80xxxxxx, ack after 3 cycles:
  - mem_be=1000 and mem_addr=0x100 while waiting.
  - stall high for 3 cycles.
  - Then wb_data=0xFFFFFF80.
  - The unsigned variant gives 0x00000080.
- Half store at addr 0x22 with data 0xABCD1234 → mem_we=1, mem_be=1100, mem_wdata=0x12341234. Write-back follows ack.
- Word load at addr 0x6 → no mem_req, next cycle err=1, err_pc=pc, wb_we=0.
- Load with mem_ack never asserted, TIMEOUT=16 → mem_req high for 16 cycles, then err=1 and stall=0. The next ALU op is accepted the following cycle.
